// File: rtl/la_rle_trace_packer_if.sv
// rtl/la_rle_trace_packer_if.sv - AXI-Stream record bus carrying {repeat_count, signals} trace records
interface la_rle_trace_packer_if #(
  parameter int pDATA_W = 32
);
  localparam int BW = (pDATA_W + 7) / 8;

  logic [pDATA_W-1:0] tdata;
  logic [BW-1:0]      tstrb;
  logic [BW-1:0]      tkeep;
  logic [1:0]         tuser;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport master (output tdata, tstrb, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tstrb, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/la_rle_trace_packer.sv
// rtl/la_rle_trace_packer.sv - masked probe RLE encoder with record FIFO and AXI-Stream output
// Optional LA_DROP_COUNT_EN: overflow marker carries a saturating count of dropped records.
module la_rle_trace_packer #(
  parameter int pSIG_WIDTH = 24,
  parameter int pRC_WIDTH  = 8,
  parameter int pFIFO_AW   = 6
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic                  la_en,
  input  logic                  soft_clr,
  input  logic [pSIG_WIDTH-1:0] la_mask,
  input  logic [pFIFO_AW:0]     hi_thresh,
  input  logic [pFIFO_AW:0]     lo_thresh,
  input  logic [pSIG_WIDTH-1:0] up_la_data,
  la_rle_trace_packer_if.master m,
  output logic                  la_hpri_req,
  output logic [pFIFO_AW:0]     fifo_count
);
  localparam int DW    = pRC_WIDTH + pSIG_WIDTH;
  localparam int EW    = DW + 2;
  localparam int DEPTH = 1 << pFIFO_AW;
  localparam logic [pRC_WIDTH-1:0] RCMAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [pSIG_WIDTH-1:0] cur_sig_q, cur_sig_d;
  logic [pRC_WIDTH-1:0]  cur_rc_q, cur_rc_d;
  logic                  ovf_q, ovf_d;
  logic                  hpri_q, hpri_d;
  logic [pFIFO_AW:0]     wr_ptr_q, wr_ptr_d;
  logic [pFIFO_AW:0]     rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]         mem_q [DEPTH];

  logic [pSIG_WIDTH-1:0] s;
  logic [pSIG_WIDTH-1:0] marker_sig;
  logic [pFIFO_AW:0]     count;
  logic                  full, empty, pop, space;
  logic                  emit, emit_last, marker_wr, wr_en, drop;
  logic [DW-1:0]         emit_data;
  logic [EW-1:0]         wr_entry, rd_entry;

  assign s     = up_la_data & la_mask;
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (pFIFO_AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && m.tready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts a write.
  assign space = !full || pop;

  // Entry layout: {tlast, overflow marker, rc, sig}
  assign rd_entry   = mem_q[rd_ptr_q[pFIFO_AW-1:0]];
  assign m.tvalid   = !empty;
  assign m.tdata    = empty ? '0 : rd_entry[DW-1:0];
  assign m.tuser    = {1'b0, !empty && rd_entry[DW]};
  assign m.tlast    = !empty && rd_entry[DW+1];
  assign m.tstrb    = '1;
  assign m.tkeep    = '1;
  assign la_hpri_req = hpri_q;
  assign fifo_count  = count;

  always_comb begin
    state_d   = state_q;
    cur_sig_d = cur_sig_q;
    cur_rc_d  = cur_rc_q;
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_data = {cur_rc_q, cur_sig_q};
    case (state_q)
      IDLE: begin
        if (la_en) begin
          state_d   = RUN;
          cur_sig_d = s;
          cur_rc_d  = pRC_WIDTH'(1);
        end
      end
      RUN: begin
        if (!la_en) begin
          state_d = FLUSH;
        end else if (s == cur_sig_q && cur_rc_q != RCMAX) begin
          cur_rc_d = cur_rc_q + pRC_WIDTH'(1);
        end else begin
          emit      = 1'b1;
          cur_sig_d = s;
          cur_rc_d  = pRC_WIDTH'(1);
        end
      end
      FLUSH: begin
        // A pending marker goes out first; the final run follows on a later cycle.
        if (!ovf_q && space) begin
          emit      = 1'b1;
          emit_last = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    marker_wr = ovf_q && space;
    drop      = emit && (!space || marker_wr);
    wr_en     = marker_wr || (emit && space);
    ovf_d     = (ovf_q && !marker_wr) || drop;
    wr_entry  = marker_wr ? {1'b0, 1'b1, {pRC_WIDTH{1'b0}}, marker_sig}
                          : {emit_last, 1'b0, emit_data};
    wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    if (count >= hi_thresh)      hpri_d = 1'b1;
    else if (count <= lo_thresh) hpri_d = 1'b0;
    else                         hpri_d = hpri_q;

    if (soft_clr) begin
      state_d   = IDLE;
      cur_sig_d = '0;
      cur_rc_d  = '0;
      ovf_d     = 1'b0;
      wr_en     = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      hpri_d    = 1'b0;
    end
  end

`ifdef LA_DROP_COUNT_EN
  logic [pSIG_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (soft_clr)
      drop_cnt_d = '0;
    else if (marker_wr)
      drop_cnt_d = pSIG_WIDTH'(drop);
    else if (drop && drop_cnt_q != '1)
      drop_cnt_d = drop_cnt_q + pSIG_WIDTH'(1);
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) drop_cnt_q <= '0;
    else              drop_cnt_q <= drop_cnt_d;
  end

  assign marker_sig = drop_cnt_q;
`else
  assign marker_sig = '0;
`endif

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q   <= IDLE;
      cur_sig_q <= '0;
      cur_rc_q  <= '0;
      ovf_q     <= 1'b0;
      hpri_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cur_sig_q <= cur_sig_d;
      cur_rc_q  <= cur_rc_d;
      ovf_q     <= ovf_d;
      hpri_q    <= hpri_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (wr_en) mem_q[wr_ptr_q[pFIFO_AW-1:0]] <= wr_entry;
  end
endmodule

// File: doc/la_rle_trace_packer.md
Name: la_rle_trace_packer

Overview:
- Parametrised second-generation trace front end for the logic analyser.
- Masks the user-project probe bus, then run-length encodes it into {repeat_count, signals} records.
- Records are buffered in an internal FIFO and streamed out on AXI-Stream.
- Compared with the fixed 24/8-bit first generation, it adds:
  - generic signal and repeat-count widths and FIFO depth;
  - explicit overflow markers;
  - end-of-capture tlast;
  - hysteretic high-priority request.

Parameters:
pSIG_WIDTH, 24, probe/signal field width (1..56)
pRC_WIDTH, 8, repeat-count field width (2..8); max count RCMAX = 2^pRC_WIDTH-1
pFIFO_AW, 6, FIFO address width; depth = 2^pFIFO_AW records

Ports:
axi_clk  in  1  single clock for all logic
axi_reset_n  in  1  asynchronous active-low reset
la_en  in  1  capture enable; rising edge starts a run, falling edge flushes
soft_clr  in  1  synchronous clear of FIFO, encoder and overflow state (1-cycle pulse)
la_mask  in  pSIG_WIDTH  per-bit monitor enable; masked bits read as 0
hi_thresh  in  pFIFO_AW+1  la_hpri_req set level
lo_thresh  in  pFIFO_AW+1  la_hpri_req clear level
up_la_data  in  pSIG_WIDTH  probe bus
m_tdata  out  pRC_WIDTH+pSIG_WIDTH  {rc, sig}
m_tstrb  out  ceil(W/8)  all ones
m_tkeep  out  ceil(W/8)  all ones
m_tuser  out  2  bit0=overflow marker, bit1=0
m_tlast  out  1  final record of a capture
m_tvalid  out  1  record available
m_tready  in  1  sink accept
la_hpri_req  out  1  FIFO-level request to the stream arbiter
fifo_count  out  pFIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (axi_reset_n=0):
  - state=IDLE; FIFO empty; ovf_pending=0.
  - m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, la_hpri_req=0, fifo_count=0.
- Sample: s = up_la_data & la_mask, taken every cycle while in RUN.
- FSM IDLE:
  - la_en=1 → RUN; the first sample loads cur_sig=s, cur_rc=1.
- FSM RUN, each cycle:
  - s==cur_sig and cur_rc<RCMAX → cur_rc++.
  - s==cur_sig and cur_rc==RCMAX → emit {RCMAX,cur_sig}; cur_rc=1.
  - s!=cur_sig → emit {cur_rc,cur_sig}; cur_sig=s, cur_rc=1.
  - la_en=0 → FLUSH. The sample in that cycle is not taken.
- FSM FLUSH:
  - Stalls until the FIFO has space.
  - If ovf_pending, writes the marker first, then the final run with tlast=1.
  - Then → IDLE.
- Emit in RUN when the FIFO is full: the record is dropped and ovf_pending=1.
- Marker write:
  - Written at the first cycle with ovf_pending=1 and the FIFO not full.
  - Marker content: rc field=0, sig field=0, tuser[0]=1.
  - A RUN emit in the same cycle is dropped and counted as overflow.
  - ovf_pending clears when the marker is written.
- FIFO: one write and one read per cycle.
  - Simultaneous push+pop is legal when full: the pop frees the slot in the same cycle.
  - Pointers wrap modulo depth; occupancy uses an extra bit.
- AXIS output:
  - m_tvalid = FIFO non-empty; latency is 1 cycle from write to m_tvalid.
  - While m_tvalid=1 and m_tready=0, m_tdata, m_tuser and m_tlast are held stable.
  - Pop occurs on m_tvalid&m_tready.
- la_hpri_req: set when fifo_count>=hi_thresh, cleared when fifo_count<=lo_thresh, otherwise holds. If hi<=lo, the set condition wins.
- soft_clr:
  - Has priority over everything.
  - Empties the FIFO, state=IDLE, ovf_pending=0, la_hpri_req=0, in the next cycle.
  - A partial run is discarded without a record.
- la_en toggling in IDLE while the FIFO drains is legal; the old records are retained.

Optional Feature:
- LA_DROP_COUNT_EN defined:
  - A saturating drop counter of width pSIG_WIDTH increments per dropped record.
  - The marker's sig field carries the counter value; the counter clears when the marker is written.
- Undefined: marker sig field = 0 and no counter exists.

Test Plan:
- Mask: defaults, la_mask=0x5A5A5A, up_la_data 0x00005A, 0x0000FF, 0x000055 one cycle each, then la_en=0, m_tready=1 → records {0x02,0x00005A} tlast=0, then {0x01,0x000050} tlast=1.
- Saturation: constant 0x123456 for 600 cycles, then la_en=0 → {0xFF,0x123456}, {0xFF,0x123456}, {0x5A,0x123456} with tlast on the third.
- Overflow: pFIFO_AW=4, m_tready=0, incrementing data for 40 cycles; then m_tready=1 →
  - 16 records 0x01/0x00..0x0F stream first;
  - then one marker {0x00,0x000000} with tuser=01;
  - then surviving records continue.
- Overflow with LA_DROP_COUNT_EN: same stimulus → marker sig field equals the exact drop count.
- Hysteresis: hi=12, lo=4, tready=0, fill to 12 → la_hpri_req=1; drain to 5 → still 1; drain to 4 → 0.
- Backpressure: m_tready high 1 cycle in 3, random data → no record lost or reordered, tdata stable while stalled.
- Reset: axi_reset_n low mid-RUN with 5 records queued → all outputs 0 immediately; after release no stale record appears.
- soft_clr: pulse mid-RUN with 5 records queued → same outcome.
